// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and its request sequencer.
// Latency: none (types, constants and a pure helper only).
// Backpressure: not applicable.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;

  // Sequencer FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } seq_state_t;

  // Opcodes above NOT (110, 111) have no ALU function.
  function automatic logic op_reserved(input logic [2:0] op);
    return (op > OP_NOT);
  endfunction

endpackage

// File: rtl/ALU.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR/NOT over a (W_size+1)-bit result.
// Latency: zero cycles, purely combinational.
// Backpressure: none; outputs follow inputs continuously.
module ALU
  import alu_pkg::*;
#(
  parameter int W_size = 8
) (
  input  logic [W_size-1:0] A,
  input  logic [W_size-1:0] B,
  input  logic [2:0]        s,
  input  logic              cin,
  output logic [W_size-1:0] C_out,
  output logic              zero,
  output logic              Of
);

  logic [W_size:0] full;

  // Full-width result; bit W_size is the carry (ADD) or borrow (SUB).
  always_comb begin
    full = '0;
    case (s)
      OP_ADD:  full = {1'b0, A} + {1'b0, B} + {{W_size{1'b0}}, cin};
      OP_SUB:  full = {1'b0, A} - {1'b0, B};
      OP_AND:  full = {1'b0, A & B};
      OP_OR:   full = {1'b0, A | B};
      OP_XOR:  full = {1'b0, A ^ B};
      OP_NOT:  full = {1'b0, ~A};
      default: full = '0;
    endcase
  end

  assign C_out = full[W_size-1:0];
  assign Of    = full[W_size];
  assign zero  = (full == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Registers requests onto the ALU inputs, captures result/flags, holds the response, tracks chain carry.
// Latency: valid op -> rsp_valid 1 cycle after accept edge; reserved op -> rsp_valid right after accept edge.
// Backpressure: rsp_ready low holds RESP with all outputs frozen; req_ready is high only in IDLE.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int W_size = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [W_size-1:0] req_a,
  input  logic [W_size-1:0] req_b,
  input  logic              req_chain,
  output logic [W_size-1:0] alu_a,
  output logic [W_size-1:0] alu_b,
  output logic [2:0]        alu_s,
  output logic              alu_cin,
  input  logic [W_size-1:0] alu_res,
  input  logic              alu_zero,
  input  logic              alu_of,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W_size-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_of,
  output logic              rsp_err,
  output logic              carry_q,
  output logic [15:0]       stat_ops
);

  seq_state_t state, state_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: accept in IDLE, one capture cycle for real ops, hold RESP until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = op_reserved(req_op) ? RESP : EXEC;
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode state only, so there is no input-to-output path.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // ALU drive, response capture, chain carry and completed-op counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_s    <= OP_ADD;
      alu_cin  <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_of   <= 1'b0;
      rsp_err  <= 1'b0;
      carry_q  <= 1'b0;
      stat_ops <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (op_reserved(req_op)) begin
              // ALU drive is left alone; the error response is built directly.
              rsp_data <= '0;
              rsp_zero <= 1'b0;
              rsp_of   <= 1'b0;
              rsp_err  <= 1'b1;
            end else begin
              alu_a   <= req_a;
              alu_b   <= req_b;
              alu_s   <= req_op;
              alu_cin <= (req_op == OP_ADD && req_chain) ? carry_q : 1'b0;
            end
          end
        end
        EXEC: begin
          rsp_data <= alu_res;
          rsp_zero <= alu_zero;
          rsp_of   <= alu_of;
          rsp_err  <= 1'b0;
          // Only arithmetic ops produce a carry/borrow worth chaining.
          if (alu_s == OP_ADD || alu_s == OP_SUB) carry_q <= alu_of;
        end
        RESP: begin
          if (rsp_ready) stat_ops <= stat_ops + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'b000;
  logic [7:0] req_a = 8'h00;
  logic [7:0] req_b = 8'h00;
  logic       req_chain = 1'b0;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_s;
  logic       alu_cin;
  logic [7:0] alu_res;
  logic       alu_zero, alu_of;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_zero, rsp_of, rsp_err;
  logic       carry_q;
  logic [15:0] stat_ops;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.W_size(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_chain(req_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_of(rsp_of), .rsp_err(rsp_err),
    .carry_q(carry_q), .stat_ops(stat_ops)
  );

  ALU #(.W_size(8)) u_alu (
    .A(alu_a), .B(alu_b), .s(alu_s), .cin(alu_cin),
    .C_out(alu_res), .zero(alu_zero), .Of(alu_of)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request for exactly one edge; returns 1 time unit after the accept edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ch);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_chain = ch;
    @(posedge clk);
    #1 req_valid = 1'b0; req_chain = 1'b0;
  endtask

  // Take the response on the next edge (called from a negedge while in RESP).
  task automatic take();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_s", alu_s, 0);
    chk("rst_carry", carry_q, 0);
    chk("rst_stat", stat_ops, 0);
    @(negedge clk); rst_n = 1'b1;

    // ADD 0F+01, no chain
    send(OP_ADD, 8'h0F, 8'h01, 1'b0);
    @(negedge clk);
    chk("add1_exec_valid", rsp_valid, 0);
    chk("add1_exec_ready", req_ready, 0);
    chk("add1_cin", alu_cin, 0);
    chk("add1_alu_a", alu_a, 8'h0F);
    @(negedge clk);
    chk("add1_valid", rsp_valid, 1);
    chk("add1_data", rsp_data, 8'h10);
    chk("add1_zero", rsp_zero, 0);
    chk("add1_of", rsp_of, 0);
    chk("add1_carry", carry_q, 0);
    take();
    chk("add1_stat", stat_ops, 1);

    // ADD FF+01: carry out, low bits zero but zero flag clear
    send(OP_ADD, 8'hFF, 8'h01, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("add2_data", rsp_data, 8'h00);
    chk("add2_of", rsp_of, 1);
    chk("add2_zero", rsp_zero, 0);
    chk("add2_carry", carry_q, 1);
    take();

    // Chained ADD 00+00 consumes the stored carry
    send(OP_ADD, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    chk("chain_cin", alu_cin, 1);
    @(negedge clk);
    chk("chain_data", rsp_data, 8'h01);
    chk("chain_of", rsp_of, 0);
    chk("chain_carry", carry_q, 0);
    take();
    chk("chain_stat", stat_ops, 3);

    // Set carry again, then AND must leave it alone
    send(OP_ADD, 8'hFF, 8'h01, 1'b0);
    @(negedge clk); @(negedge clk);
    take();
    send(OP_AND, 8'hF0, 8'h0F, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("and_data", rsp_data, 8'h00);
    chk("and_zero", rsp_zero, 1);
    chk("and_carry", carry_q, 1);
    take();

    // Reserved opcode 110: error response one cycle after accept, ALU drive untouched
    send(3'b110, 8'h12, 8'h34, 1'b0);
    @(negedge clk);
    chk("rsv_valid", rsp_valid, 1);
    chk("rsv_err", rsp_err, 1);
    chk("rsv_data", rsp_data, 0);
    chk("rsv_zero", rsp_zero, 0);
    chk("rsv_alu_s", alu_s, OP_AND);
    chk("rsv_alu_a", alu_a, 8'hF0);
    take();
    chk("rsv_stat", stat_ops, 6);

    // SUB 05-03 clears carry and the error flag
    send(OP_SUB, 8'h05, 8'h03, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("sub_data", rsp_data, 8'h02);
    chk("sub_err", rsp_err, 0);
    chk("sub_carry", carry_q, 0);
    take();

    // Backpressure: XOR held in RESP for 5 cycles while the next request waits
    send(OP_XOR, 8'hAA, 8'hFF, 1'b0);
    @(negedge clk); @(negedge clk);
    req_valid = 1'b1; req_op = OP_OR; req_a = 8'h01; req_b = 8'h02;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_ready", req_ready, 0);
      chk("bp_data", rsp_data, 8'h55);
      chk("bp_alu_s", alu_s, OP_XOR);
      @(negedge clk);
    end
    take();
    chk("bp_stat", stat_ops, 8);
    @(negedge clk);
    chk("bp_idle_ready", req_ready, 1);
    chk("bp_idle_alu_s", alu_s, OP_XOR);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_alu_s", alu_s, OP_OR);
    @(negedge clk);
    chk("bp_next_data", rsp_data, 8'h03);
    take();
    chk("bp_next_stat", stat_ops, 9);

    // Reset during EXEC: op dropped, outputs to reset values at once
    send(OP_ADD, 8'hFF, 8'h01, 1'b0);
    @(negedge clk); @(negedge clk);
    take();
    chk("pre_rst_carry", carry_q, 1);
    send(OP_AND, 8'h3C, 8'h0F, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_carry", carry_q, 0);
    chk("arst_ready", req_ready, 1);
    chk("arst_stat", stat_ops, 0);
    chk("arst_alu_a", alu_a, 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_rsp", rsp_valid, 0);
    end

    // Counter wrap from 0xFFFE
    @(negedge clk);
    force dut.stat_ops = 16'hFFFE;
    #1 release dut.stat_ops;
    send(OP_NOT, 8'h0F, 8'h00, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("not_data", rsp_data, 8'hF0);
    take();
    chk("wrap_ffff", stat_ops, 16'hFFFF);
    send(3'b111, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("rsv7_err", rsp_err, 1);
    take();
    chk("wrap_zero", stat_ops, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
